// File: rtl/dcache_refill_ctrl.sv
// Data-cache miss engine: optional dirty-victim writeback, then a 4-beat line refill.
// Optional feature macro: REFILL_EARLY_RESTART_EN (adds crit_valid/crit_data early-restart outputs).
module dcache_refill_ctrl #(
    parameter logic [2:0]  LINE_TYPE = 3'b100,
    parameter int unsigned WB_GUARD  = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         miss_req,
    input  logic [31:0]  miss_addr,
    input  logic         miss_dirty,
    input  logic [31:0]  victim_addr,
    input  logic [127:0] victim_data,
    output logic         miss_ready,
    output logic         refill_valid,
    output logic [31:0]  refill_addr,
    output logic [127:0] refill_data,
    output logic         refill_err,
    output logic         rd_req,
    output logic [2:0]   rd_type,
    output logic [31:0]  rd_addr,
    input  logic         rd_rdy,
    input  logic         ret_valid,
    input  logic         ret_last,
    input  logic [31:0]  ret_data,
    output logic         wr_req,
    output logic [2:0]   wr_type,
    output logic [31:0]  wr_addr,
    output logic [3:0]   wr_wstrb,
    output logic [127:0] wr_data,
    input  logic         wr_rdy
`ifdef REFILL_EARLY_RESTART_EN
    ,
    output logic         crit_valid,
    output logic [31:0]  crit_data
`endif
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WB_REQ  = 3'd1;
    localparam logic [2:0] WB_WAIT = 3'd2;
    localparam logic [2:0] RD_REQ  = 3'd3;
    localparam logic [2:0] REFILL  = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    localparam logic [1:0] GUARD_MAX = 2'(WB_GUARD);

    logic [2:0]   state_q, state_d;
    logic [27:0]  lineAddr_q;
    logic [1:0]   critIdx_q;
    logic [27:0]  victimAddr_q;
    logic [127:0] victimData_q;
    logic [127:0] buf_q;
    logic [127:0] refillData_q;
    logic [1:0]   cnt_q;
    logic [1:0]   guard_q;
    logic         err_q;

    logic         accept;
    logic         wrHandshake;
    logic         rdHandshake;
    logic         refillBeat;
    logic         beatDone;
    logic         beatErr;
    logic         guardDone;
    logic [127:0] lineNext;

    assign accept      = (state_q == IDLE) && miss_req;
    assign wrHandshake = (state_q == WB_REQ) && wr_rdy;
    assign rdHandshake = (state_q == RD_REQ) && rd_rdy;
    assign refillBeat  = (state_q == REFILL) && ret_valid;
    assign beatDone    = refillBeat && (ret_last || (cnt_q == 2'd3));
    assign beatErr     = ret_last != (cnt_q == 2'd3);
    assign guardDone   = (guard_q == GUARD_MAX);

    always_comb begin
        lineNext = buf_q;
        case (cnt_q)
            2'd0:    lineNext[31:0]   = ret_data;
            2'd1:    lineNext[63:32]  = ret_data;
            2'd2:    lineNext[95:64]  = ret_data;
            default: lineNext[127:96] = ret_data;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (miss_req) state_d = miss_dirty ? WB_REQ : RD_REQ;
            WB_REQ:  if (wr_rdy) state_d = WB_WAIT;
            // The bridge drops wr_rdy only a cycle after acceptance, so its value is
            // meaningless until the guard window has passed.
            WB_WAIT: if (guardDone && wr_rdy) state_d = RD_REQ;
            RD_REQ:  if (rd_rdy) state_d = REFILL;
            REFILL:  if (beatDone) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            lineAddr_q   <= '0;
            critIdx_q    <= '0;
            victimAddr_q <= '0;
            victimData_q <= '0;
            buf_q        <= '0;
            refillData_q <= '0;
            cnt_q        <= '0;
            guard_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                lineAddr_q   <= miss_addr[31:4];
                critIdx_q    <= miss_addr[3:2];
                victimAddr_q <= victim_addr[31:4];
                victimData_q <= victim_data;
                buf_q        <= '0;
                cnt_q        <= '0;
            end
            if (refillBeat) begin
                buf_q <= lineNext;
                cnt_q <= cnt_q + 2'd1;
            end
            // A short or overlong burst still completes the line; the error is sticky.
            if (beatDone) begin
                refillData_q <= lineNext;
                if (beatErr) err_q <= 1'b1;
            end
            if (wrHandshake) begin
                guard_q <= '0;
            end else if ((state_q == WB_WAIT) && !guardDone) begin
                guard_q <= guard_q + 2'd1;
            end
        end
    end

`ifdef REFILL_EARLY_RESTART_EN
    logic        critValid_q;
    logic        critDone_q;
    logic [31:0] critData_q;
    logic        critFire;

    assign critFire = refillBeat && (cnt_q == critIdx_q) && !critDone_q;

    // The requested word is forwarded once per miss, as soon as its beat lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            critValid_q <= 1'b0;
            critDone_q  <= 1'b0;
            critData_q  <= '0;
        end else begin
            critValid_q <= critFire;
            if (accept) critDone_q <= 1'b0;
            if (critFire) begin
                critDone_q <= 1'b1;
                critData_q <= ret_data;
            end
        end
    end

    assign crit_valid = critValid_q;
    assign crit_data  = critData_q;
`endif

    assign miss_ready   = (state_q == IDLE);
    assign refill_valid = (state_q == DONE);
    assign refill_addr  = {lineAddr_q, 4'b0000};
    assign refill_data  = refillData_q;
    assign refill_err   = err_q;

    assign rd_req   = (state_q == RD_REQ);
    assign rd_type  = rd_req ? LINE_TYPE : 3'b000;
    assign rd_addr  = {lineAddr_q, 4'b0000};

    assign wr_req   = (state_q == WB_REQ);
    assign wr_type  = wr_req ? LINE_TYPE : 3'b000;
    assign wr_wstrb = wr_req ? 4'hF : 4'h0;
    assign wr_addr  = {victimAddr_q, 4'b0000};
    assign wr_data  = victimData_q;

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Self-checking bench for dcache_refill_ctrl: directed and randomized misses against a line-level model.
// Early-restart checks are compiled in when REFILL_EARLY_RESTART_EN is defined.
module tb_dcache_refill_ctrl;

    localparam logic [2:0] LINE_TYPE = 3'b100;
    localparam int         WB_GUARD  = 1;

    logic         clk;
    logic         reset;
    logic         miss_req;
    logic [31:0]  miss_addr;
    logic         miss_dirty;
    logic [31:0]  victim_addr;
    logic [127:0] victim_data;
    logic         miss_ready;
    logic         refill_valid;
    logic [31:0]  refill_addr;
    logic [127:0] refill_data;
    logic         refill_err;
    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy;
    logic         ret_valid;
    logic         ret_last;
    logic [31:0]  ret_data;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy;
`ifdef REFILL_EARLY_RESTART_EN
    logic         crit_valid;
    logic [31:0]  crit_data;
`endif

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    logic errModel = 1'b0;

    dcache_refill_ctrl #(.LINE_TYPE(LINE_TYPE), .WB_GUARD(WB_GUARD)) dut (
        .clk(clk), .reset(reset),
        .miss_req(miss_req), .miss_addr(miss_addr), .miss_dirty(miss_dirty),
        .victim_addr(victim_addr), .victim_data(victim_data),
        .miss_ready(miss_ready), .refill_valid(refill_valid), .refill_addr(refill_addr),
        .refill_data(refill_data), .refill_err(refill_err),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy)
`ifdef REFILL_EARLY_RESTART_EN
        , .crit_valid(crit_valid), .crit_data(crit_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkCrit(input int lastBeat, input int critIdx, input logic [31:0] critWord);
`ifdef REFILL_EARLY_RESTART_EN
        checkOutput("crit_valid", 128'(crit_valid), 128'(lastBeat == critIdx));
        if (lastBeat == critIdx) checkOutput("crit_data", 128'(crit_data), 128'(critWord));
`else
        if (lastBeat < 0 && critIdx < 0) $display("[TB] crit %h", critWord);
`endif
    endtask

    // One complete miss; the model is the line-level rule: words up to the completing
    // beat are kept, the rest are zero, and any burst not ending exactly on beat 3 is an error.
    task automatic applyStimulus(input logic [31:0] addr, input logic dirty,
                                 input logic [31:0] vaddr, input logic [127:0] vdata,
                                 input logic [127:0] beats, input int lastIdx,
                                 input int rdStall, input int wrHold, input bit gaps,
                                 input bit checkLat);
        logic [127:0] expLine;
        logic [31:0]  expAddr;
        int           c;
        int           n;
        int           startCyc;
        int           critIdx;
        int           gap;

        expAddr = {addr[31:4], 4'h0};
        c       = (lastIdx < 3) ? lastIdx : 3;
        critIdx = int'(addr[3:2]);
        expLine = '0;
        for (int i = 0; i <= c; i++) expLine[32*i +: 32] = beats[32*i +: 32];

        checkOutput("miss_ready_idle", 128'(miss_ready), 128'd1);
        miss_req    = 1'b1;
        miss_addr   = addr;
        miss_dirty  = dirty;
        victim_addr = vaddr;
        victim_data = vdata;
        rd_rdy      = (rdStall == 0);
        wr_rdy      = 1'b1;
        tick();
        startCyc    = cyc - 1;
        miss_req    = 1'b0;
        miss_addr   = $urandom;
        miss_dirty  = ~dirty;
        victim_addr = $urandom;
        victim_data = {$urandom, $urandom, $urandom, $urandom};
        checkOutput("miss_ready_busy", 128'(miss_ready), 128'd0);

        if (dirty) begin
            checkOutput("wr_req", 128'(wr_req), 128'd1);
            checkOutput("wr_addr", 128'(wr_addr), 128'({vaddr[31:4], 4'h0}));
            checkOutput("wr_data", wr_data, vdata);
            checkOutput("wr_wstrb", 128'(wr_wstrb), 128'hF);
            checkOutput("wr_type", 128'(wr_type), 128'(LINE_TYPE));
            checkOutput("rd_req_during_wb", 128'(rd_req), 128'd0);
            tick();
            checkOutput("wr_req_drop", 128'(wr_req), 128'd0);
            n = 0;
            while (rd_req !== 1'b1 && n < 20) begin
                n++;
                wr_rdy = (n > wrHold);
                tick();
            end
            checkOutput("wb_to_rd_cycles", 128'(n), 128'(((wrHold > WB_GUARD) ? wrHold : WB_GUARD) + 1));
        end

        checkOutput("rd_req", 128'(rd_req), 128'd1);
        checkOutput("rd_addr", 128'(rd_addr), 128'(expAddr));
        checkOutput("rd_type", 128'(rd_type), 128'(LINE_TYPE));
        checkOutput("wr_req_in_rd", 128'(wr_req), 128'd0);
        rd_rdy = 1'b0;
        for (int s = 0; s < rdStall; s++) begin
            miss_req = 1'($urandom_range(0, 1));
            tick();
            checkOutput("rd_req_stall", 128'(rd_req), 128'd1);
            checkOutput("rd_addr_stall", 128'(rd_addr), 128'(expAddr));
            checkOutput("miss_ready_stall", 128'(miss_ready), 128'd0);
        end
        miss_req = 1'b0;
        rd_rdy   = 1'b1;
        tick();
        rd_rdy = 1'b0;
        checkOutput("rd_req_drop", 128'(rd_req), 128'd0);

        for (int i = 0; i <= c; i++) begin
            gap = gaps ? $urandom_range(0, 2) : 0;
            for (int g = 0; g < gap; g++) begin
                tick();
                checkOutput("refill_valid_gap", 128'(refill_valid), 128'd0);
                checkCrit(-1, critIdx, beats[32*critIdx +: 32]);
            end
            ret_valid = 1'b1;
            ret_data  = beats[32*i +: 32];
            ret_last  = (i == lastIdx);
            tick();
            ret_valid = 1'b0;
            ret_last  = 1'b0;
            checkCrit(i, critIdx, beats[32*critIdx +: 32]);
            if (i < c) checkOutput("refill_valid_early", 128'(refill_valid), 128'd0);
        end

        errModel = errModel | (lastIdx != 3);
        checkOutput("refill_valid", 128'(refill_valid), 128'd1);
        checkOutput("refill_data", refill_data, expLine);
        checkOutput("refill_addr", 128'(refill_addr), 128'(expAddr));
        checkOutput("refill_err", 128'(refill_err), 128'(errModel));
        if (checkLat) checkOutput("latency", 128'(cyc - startCyc), 128'd6);

        if (lastIdx > 3) begin
            ret_valid = 1'b1;
            ret_last  = 1'b1;
            ret_data  = $urandom;
        end
        tick();
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        checkOutput("refill_valid_pulse", 128'(refill_valid), 128'd0);
        checkOutput("miss_ready_after", 128'(miss_ready), 128'd1);
        checkOutput("refill_data_hold", refill_data, expLine);
        checkOutput("refill_err_hold", 128'(refill_err), 128'(errModel));
        checkCrit(-1, critIdx, beats[32*critIdx +: 32]);
    endtask

    initial begin
        int r;
        int lastIdx;

        reset       = 1'b1;
        miss_req    = 1'b0;
        miss_addr   = '0;
        miss_dirty  = 1'b0;
        victim_addr = '0;
        victim_data = '0;
        rd_rdy      = 1'b0;
        ret_valid   = 1'b0;
        ret_last    = 1'b0;
        ret_data    = '0;
        wr_rdy      = 1'b1;
        tick();
        tick();
        checkOutput("rst_miss_ready", 128'(miss_ready), 128'd1);
        checkOutput("rst_refill_valid", 128'(refill_valid), 128'd0);
        checkOutput("rst_rd_req", 128'(rd_req), 128'd0);
        checkOutput("rst_wr_req", 128'(wr_req), 128'd0);
        checkOutput("rst_refill_err", 128'(refill_err), 128'd0);
        checkOutput("rst_refill_data", refill_data, 128'd0);
        checkOutput("rst_wr_wstrb", 128'(wr_wstrb), 128'd0);
        reset = 1'b0;
        tick();

        $display("[TB] clean miss");
        applyStimulus(32'h0000_1234, 1'b0, 32'h0, 128'h0,
                      {32'h44, 32'h33, 32'h22, 32'h11}, 3, 0, 0, 1'b0, 1'b1);
        checkOutput("t1_line", refill_data, 128'h00000044_00000033_00000022_00000011);

        $display("[TB] dirty miss with writeback hold");
        applyStimulus(32'h0000_5678, 1'b1, 32'h8000_0040, {32{4'hA}},
                      {$urandom, $urandom, $urandom, $urandom}, 3, 0, 4, 1'b0, 1'b0);

        $display("[TB] read stall with ignored miss pulses");
        applyStimulus(32'h0000_9AB0, 1'b0, 32'h0, 128'h0,
                      {$urandom, $urandom, $urandom, $urandom}, 3, 5, 0, 1'b0, 1'b0);

        $display("[TB] short burst");
        applyStimulus(32'h0000_0104, 1'b0, 32'h0, 128'h0,
                      {32'hD3, 32'hC2, 32'hB1, 32'hA0}, 1, 0, 0, 1'b0, 1'b0);

        $display("[TB] burst without last");
        applyStimulus(32'h0000_0200, 1'b1, 32'h0000_0300, {4{$urandom}},
                      {$urandom, $urandom, $urandom, $urandom}, 4, 1, 0, 1'b1, 1'b0);

        $display("[TB] reset during refill");
        miss_req  = 1'b1;
        miss_addr = 32'h0000_4440;
        miss_dirty = 1'b0;
        rd_rdy    = 1'b1;
        tick();
        miss_req = 1'b0;
        tick();
        rd_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ret_valid = 1'b1;
            ret_data  = $urandom;
            tick();
        end
        reset    = 1'b1;
        errModel = 1'b0;
        #1;
        checkOutput("rstmid_miss_ready", 128'(miss_ready), 128'd1);
        checkOutput("rstmid_refill_valid", 128'(refill_valid), 128'd0);
        checkOutput("rstmid_rd_req", 128'(rd_req), 128'd0);
        checkOutput("rstmid_refill_err", 128'(refill_err), 128'd0);
        checkOutput("rstmid_refill_data", refill_data, 128'd0);
        checkOutput("rstmid_refill_addr", 128'(refill_addr), 128'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ret_valid = 1'b1;
            ret_last  = (i == 1);
            ret_data  = $urandom;
            tick();
            checkOutput("rstmid_stray_valid", 128'(refill_valid), 128'd0);
            checkOutput("rstmid_stray_ready", 128'(miss_ready), 128'd1);
        end
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        applyStimulus(32'h0000_4440, 1'b0, 32'h0, 128'h0,
                      {$urandom, $urandom, $urandom, $urandom}, 3, 0, 0, 1'b0, 1'b1);

        $display("[TB] critical word index 2");
        applyStimulus(32'h0000_2008, 1'b0, 32'h0, 128'h0,
                      {32'h4444, 32'h3333, 32'h2222, 32'h1111}, 3, 0, 0, 1'b1, 1'b0);

        $display("[TB] randomized misses");
        for (int k = 0; k < 10; k++) begin
            r       = $urandom_range(0, 10);
            lastIdx = (r < 6) ? 3 : r - 6;
            applyStimulus($urandom, 1'($urandom_range(0, 1)), $urandom,
                          {$urandom, $urandom, $urandom, $urandom},
                          {$urandom, $urandom, $urandom, $urandom}, lastIdx,
                          $urandom_range(0, 3), $urandom_range(0, 4), 1'b1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
